// File: rtl/lrf_axis_tx.sv
// ---------------------------------------------------------------------------
// lrf_axis_tx
// AXI4-Stream transmitter for the LRF pipeline output. Processed pixel words
// from the filter core are buffered in a small circular FIFO and emitted as an
// AXI4-Stream master, with TLAST marking the final beat of every frame.
//
// Ports
//   s_axis_aclk     : single clock, rising edge
//   s_axis_aresetn  : asynchronous, active-low reset
//   in_tdata/in_tvalid/in_tready : word input from the filter core
//   m_axis_tdata/tvalid/tlast/tready : AXI4-Stream master output
//   beat_count      : input-side beat index within the current frame
//   frame_count     : number of frames whose TLAST beat left the block
//   frame_done      : one-cycle pulse after a TLAST beat is accepted
// ---------------------------------------------------------------------------
module lrf_axis_tx #(
    parameter int WORD_WIDTH      = 128,
    parameter int WORDS_PER_FRAME = 16384,
    parameter int FIFO_DEPTH      = 4,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                               s_axis_aclk,
    input  logic                               s_axis_aresetn,
    input  logic [WORD_WIDTH-1:0]              in_tdata,
    input  logic                               in_tvalid,
    output logic                               in_tready,
    output logic [WORD_WIDTH-1:0]              m_axis_tdata,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    output logic [$clog2(WORDS_PER_FRAME)-1:0] beat_count,
    output logic [FRAME_CNT_WIDTH-1:0]         frame_count,
    output logic                               frame_done
);

    localparam int BEAT_W = $clog2(WORDS_PER_FRAME);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_FRAME - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);

    // FIFO storage: data plus the end-of-frame flag captured at write time
    logic [WORD_WIDTH-1:0]      mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      mem_last_q;

    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                       frame_done_q, frame_done_d;

    logic                       full_s;
    logic                       empty_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       head_last_s;
    logic                       in_last_s;

    assign full_s      = (occ_q == OCC_FULL);
    assign empty_s     = (occ_q == OCC_W'(0));
    // Ready is held low during reset and never looks at the sink's ready,
    // so a full FIFO refuses input even in a cycle where it is popped.
    assign in_tready   = s_axis_aresetn & ~full_s;
    assign push_s      = in_tvalid & in_tready;
    assign pop_s       = ~empty_s & m_axis_tready;
    assign head_last_s = mem_last_q[rd_ptr_q];
    assign in_last_s   = (beat_q == LAST_BEAT);

    // Head of the FIFO drives the stream directly (first-word-fall-through)
    assign m_axis_tvalid = ~empty_s;
    assign m_axis_tdata  = mem_data_q[rd_ptr_q];
    assign m_axis_tlast  = ~empty_s & head_last_s;

    assign beat_count  = beat_q;
    assign frame_count = frame_cnt_q;
    assign frame_done  = frame_done_q;

    // Next-state logic for pointers, occupancy and frame bookkeeping
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        beat_d       = beat_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (in_last_s) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            frame_done_d = head_last_s;
            if (head_last_s) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control and counter registers
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            beat_q       <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            beat_q       <= beat_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FIFO storage; cleared on reset so the idle stream outputs read as zero
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
            end
            mem_last_q <= '0;
        end else if (push_s) begin
            mem_data_q[wr_ptr_q] <= in_tdata;
            mem_last_q[wr_ptr_q] <= in_last_s;
        end
    end

endmodule

// File: tb/tb_lrf_axis_tx.sv
module tb_lrf_axis_tx;

    localparam int WW    = 128;
    localparam int WPF   = 4;
    localparam int DEPTH = 4;
    localparam int FCW   = 2;
    localparam int BW    = $clog2(WPF);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WW-1:0]     in_tdata = '0;
    logic              in_tvalid = 1'b0;
    logic              in_tready;
    logic [WW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b0;
    logic [BW-1:0]     beat_count;
    logic [FCW-1:0]    frame_count;
    logic              frame_done;

    always #5 clk = ~clk;

    lrf_axis_tx #(
        .WORD_WIDTH(WW), .WORDS_PER_FRAME(WPF),
        .FIFO_DEPTH(DEPTH), .FRAME_CNT_WIDTH(FCW)
    ) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .beat_count(beat_count), .frame_count(frame_count),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [WW-1:0] data;
        logic          last;
    } exp_t;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     exp_beat = 0;
    int     done_pulses = 0;
    logic   rand_mode = 1'b0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and tracks
    // frame_done / frame_count and the AXI hold rule.
    initial begin : monitor
        logic          pend_done;
        int            fc_model;
        logic          prev_stall;
        logic [WW-1:0] prev_data;
        logic          prev_last;
        exp_t          e;
        pend_done  = 1'b0;
        fc_model   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                pend_done  = 1'b0;
                fc_model   = 0;
                prev_stall = 1'b0;
            end else begin
                chk("frame_done", {127'd0, frame_done}, {127'd0, pend_done});
                if (pend_done) begin
                    fc_model = (fc_model + 1) % (1 << FCW);
                    done_pulses++;
                end
                chk("frame_count", {126'd0, frame_count}, WW'(fc_model));
                if (prev_stall) begin
                    chk("hold_tvalid", {127'd0, m_tvalid}, 128'd1);
                    chk("hold_tdata", m_tdata, prev_data);
                    chk("hold_tlast", {127'd0, m_tlast}, {127'd0, prev_last});
                end
                pend_done = 1'b0;
                if (m_tvalid && m_tready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %h expected no output", m_tdata);
                    end else begin
                        e = sb.pop_front();
                        chk("tdata", m_tdata, e.data);
                        chk("tlast", {127'd0, m_tlast}, {127'd0, e.last});
                        pend_done = e.last;
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    // Random sink ready, active only during the random phase
    initial begin : rand_ready
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) m_tready = 1'($urandom_range(0, 1));
        end
    end

    // Drive one word and wait (bounded) until it is accepted
    task automatic send_word(input logic [WW-1:0] d, output int waits);
        bit done;
        in_tvalid = 1'b1;
        in_tdata  = d;
        waits     = 0;
        done      = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_tready) begin
                chk("beat_count", {126'd0, beat_count}, WW'(exp_beat));
                sb.push_back('{data: d, last: (exp_beat == WPF - 1)});
                exp_beat = (exp_beat + 1) % WPF;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL accept_timeout: got no in_tready expected accept of %h", d);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for the output stream to empty
    task automatic drain();
        int n;
        in_tvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (m_tvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_tvalid", {127'd0, m_tvalid}, 128'd0);
        chk("drain_sb_empty", WW'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_beat = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        int wsum;
        int d0;
        int wrap_exp[5];
        wrap_exp = '{1, 2, 3, 0, 1};

        // Reset state while reset is held
        #2;
        chk("rst_in_tready", {127'd0, in_tready}, 128'd0);
        chk("rst_tvalid", {127'd0, m_tvalid}, 128'd0);
        chk("rst_tlast", {127'd0, m_tlast}, 128'd0);
        chk("rst_tdata", m_tdata, 128'd0);
        chk("rst_frame_done", {127'd0, frame_done}, 128'd0);
        chk("rst_beat", {126'd0, beat_count}, 128'd0);
        chk("rst_frame_count", {126'd0, frame_count}, 128'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_tready", {127'd0, in_tready}, 128'd1);

        // Streaming: 8 words, two frames, 1 word/cycle
        m_tready = 1'b1;
        wsum = 0;
        d0 = done_pulses;
        for (int i = 0; i < 8; i++) begin
            send_word({120'hC0FFEE, 8'(i)}, w);
            wsum += w;
            if (i == 0) begin
                chk("latency_tvalid", {127'd0, m_tvalid}, 128'd1);
                chk("latency_tdata", m_tdata, {120'hC0FFEE, 8'h00});
            end
        end
        drain();
        chk("stream_waits", WW'(wsum), 128'd0);
        chk("stream_frame_count", {126'd0, frame_count}, 128'd2);
        chk("stream_done_pulses", WW'(done_pulses - d0), 128'd2);

        // Backpressure fill, full with simultaneous pop, then drain
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_word({120'hBEEF, 8'(i)}, w);
        in_tvalid = 1'b1;
        in_tdata  = {120'hBEEF, 8'h04};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_tready", {127'd0, in_tready}, 128'd0);
            chk("stall_tdata", m_tdata, {120'hBEEF, 8'h00});
            chk("stall_tvalid", {127'd0, m_tvalid}, 128'd1);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_tready", {127'd0, in_tready}, 128'd0);
        @(posedge clk);
        #1;
        send_word({120'hBEEF, 8'h04}, w);
        chk("accept_after_pop_waits", WW'(w), 128'd0);
        in_tvalid = 1'b0;
        m_tready  = 1'b0;
        @(negedge clk);
        chk("occ_stays_3_in_tready", {127'd0, in_tready}, 128'd1);
        @(posedge clk);
        #1;
        send_word({120'hBEEF, 8'h05}, w);
        chk("fill_again_waits", WW'(w), 128'd0);
        in_tvalid = 1'b0;
        @(negedge clk);
        chk("refull_in_tready", {127'd0, in_tready}, 128'd0);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        drain();
        chk("bp_frame_count", {126'd0, frame_count}, 128'd3);

        // Reset mid-frame with two words buffered
        pulse_reset();
        m_tready = 1'b0;
        send_word({120'hDEAD, 8'h00}, w);
        send_word({120'hDEAD, 8'h01}, w);
        in_tvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", {127'd0, m_tvalid}, 128'd0);
        chk("midrst_beat", {126'd0, beat_count}, 128'd0);
        chk("midrst_frame_count", {126'd0, frame_count}, 128'd0);
        chk("midrst_in_tready", {127'd0, in_tready}, 128'd0);
        exp_beat = 0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_word({120'hFACE, 8'(i)}, w);
        drain();
        chk("postrst_frame_count", {126'd0, frame_count}, 128'd1);

        // Random valid/ready, 16 frames
        d0 = done_pulses;
        rand_mode = 1'b1;
        for (int f = 0; f < 16; f++) begin
            for (int b = 0; b < WPF; b++) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_tvalid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                send_word({64'hD00D_0000_0000_0000, 32'(f), 32'(b)}, w);
            end
        end
        in_tvalid = 1'b0;
        rand_mode = 1'b0;
        @(posedge clk);
        #2 m_tready = 1'b1;
        drain();
        chk("rand_done_pulses", WW'(done_pulses - d0), 128'd16);
        chk("rand_frame_count", {126'd0, frame_count}, 128'd1);

        // Frame counter wrap at 2 bits
        pulse_reset();
        m_tready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < WPF; b++) send_word({96'h0, 16'hAB00 + 16'(f), 16'(b)}, w);
            drain();
            chk("wrap_frame_count", {126'd0, frame_count}, WW'(wrap_exp[f]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lrf_axis_tx.md
# lrf_axis_tx

AXI4-Stream transmitter at the output end of the LRF pipeline. It accepts 128-bit processed pixel words (16 × 8-bit pixels, pixel 0 in bits [7:0]) from the filter core through a valid/ready port. It buffers them in a small FIFO so the core keeps running while the downstream sink stalls. It emits them as an AXI4-Stream master with TLAST on the final beat of every frame. It replaces the free-running output of the core with a protocol-correct master that any AXI-Stream sink (DMA S2MM, capture bench) can consume.

## Interface
- WORD_WIDTH, 128, data word width in bits (multiple of 8)
- WORDS_PER_FRAME, 16384, beats per frame (512×512 pixels / 16); ≥ 2
- FIFO_DEPTH, 4, buffer entries; power of two, ≥ 2
- FRAME_CNT_WIDTH, 16, width of frame counter

- s_axis_aclk  in  1  single clock, rising edge
- s_axis_aresetn  in  1  reset, asynchronous, active-low
- in_tdata  in  WORD_WIDTH  word from filter core
- in_tvalid  in  1  in_tdata valid
- in_tready  out  1  block can accept a word this cycle
- m_axis_tdata  out  WORD_WIDTH  output word
- m_axis_tvalid  out  1  output word valid
- m_axis_tlast  out  1  last beat of frame
- m_axis_tready  in  1  sink accepts
- beat_count  out  $clog2(WORDS_PER_FRAME)  input-side beat index within current frame
- frame_count  out  FRAME_CNT_WIDTH  frames fully transmitted (output side)
- frame_done  out  1  one-cycle pulse when a TLAST beat is accepted by the sink

## Operation
- Input accept: in_tvalid & in_tready. On accept, the word is written to the FIFO together with a last flag = (beat_count == WORDS_PER_FRAME-1).
- beat_count: increments on each input accept. It wraps to 0 after WORDS_PER_FRAME-1, which is the frame boundary.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits and an occupancy counter of 0..FIFO_DEPTH.
  - in_tready = (occupancy != FIFO_DEPTH). It is combinational from registered occupancy and has no dependence on m_axis_tready.
  - No write when full, even if a read occurs in the same cycle. No fall-through bypass when empty.
- Output: first-word-fall-through from the FIFO head.
  - m_axis_tvalid = (occupancy != 0).
  - m_axis_tdata / m_axis_tlast = head entry.
- Output accept: m_axis_tvalid & m_axis_tready pops the head.
  - If the popped entry has last = 1: frame_done pulses next cycle, and frame_count increments next cycle (wraps modulo 2^FRAME_CNT_WIDTH).
- Simultaneous push and pop (non-full, non-empty): occupancy unchanged, and both pointers advance.
- AXI rule: once m_axis_tvalid is high, it and m_axis_tdata/m_axis_tlast hold until accepted. The block never drops or reorders words.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release on next clock edge): all of the following are cleared immediately:
  - occupancy, both pointers, beat_count, frame_count = 0
  - frame_done = 0
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0
  - in_tready = 1 after release; low while reset is asserted
- Reset mid-frame flushes all buffered words. The next accepted word is beat 0 of frame 0.
- Latency: a word accepted at edge N is visible on m_axis at edge N+1 (earliest accept by the sink at edge N+1).
- Throughput: 1 word/cycle sustained when m_axis_tready stays high.
- in_tready deasserts the cycle after occupancy reaches FIFO_DEPTH. It reasserts the cycle after a pop from full.
- frame_done / frame_count update exactly one cycle after the TLAST handshake edge.
- Back-to-back frames: beat 0 of frame k+1 may be accepted in the cycle after the last beat of frame k. No bubble is inserted.

## Test plan
Tests use WORDS_PER_FRAME=4 and FIFO_DEPTH=4 unless noted.
- Streaming: in_tvalid=1 and m_axis_tready=1 constant, 8 words 0x..00–0x..07 → output same order at 1-cycle latency; tlast on words 3 and 7; frame_done pulses twice; frame_count=2.
- Backpressure fill: m_axis_tready=0, push 6 words → in_tready low after 4 accepts; the 5th word is held by the source. m_axis_tdata holds word 0 unchanged for every stalled cycle. Raising m_axis_tready drains words 0–5 in order.
- Random valid/ready (the $random pattern, 50%), 16 frames of WORDS_PER_FRAME=16384 packed Door image words → the output word sequence matches the input exactly. Exactly 16 tlast beats occur, each at index 16383 mod 16384. frame_count=16.
- Full with simultaneous pop: FIFO full, m_axis_tready=1, in_tvalid=1 → in_tready=0 that cycle, and occupancy goes 4→3. The next cycle accepts the input, so occupancy stays 3.
- Reset mid-frame: after 2 beats of frame 0 with 2 words buffered, pulse s_axis_aresetn low between edges → m_axis_tvalid drops immediately, and beat_count and frame_count = 0. After release, the next word carries tlast after 4 beats.
- Counter wrap: FRAME_CNT_WIDTH=2, 5 frames → frame_count sequence 1,2,3,0,1.
